wb_timer: RTL
=============

Name: wb_timer

Overview:
- Wishbone classic-cycle responder (slave) for the J1 Wishbone master: a memory-mapped, 16-bit, prescaled down-counter timer with an interrupt output.
- Sits on the CPU's data bus at a fixed 8-word window.
- Provides periodic or one-shot ticks for Forth firmware.
- Answers reads and writes with a registered single-cycle ack; stays silent outside its window.

Parameters:
BASE_ADR, 16'h7FF8, word base address of the window; decode compares adr[15:3] against BASE_ADR[15:3].

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
wb  if_wb.slave  —  Wishbone bus: adr[15:0] word address, we, cyc, stb, master data, slave data[15:0], ack. When NO_MODPORT_EXPRESSIONS is defined, master data is wb.dat_m and slave data is wb.dat_s; otherwise wb.dat_i and wb.dat_o.
irq  output  1  timer interrupt, level

Behaviour:
- Register map, word offset adr[2:0]:
  - 0 CTRL: bit0 EN, bit1 IRQ_EN, bit2 AUTO (periodic); bits 15:3 read 0.
  - 1 PRESCALE: 16 bits; a tick occurs every PRESCALE+1 enabled cycles.
  - 2 COUNT: 16-bit down counter; a write loads it directly.
  - 3 RELOAD: 16 bits; reload value used in AUTO mode.
  - 4 STATUS: bit0 EXP, sticky; write 1 to bit0 clears it; other bits read 0.
  - 5-7: read 16'h0; writes ignored.
- Hit: cyc & stb & (adr[15:3] == BASE_ADR[15:3]).
- Ack generation: ack <= hit & ~ack.
  - Ack rises one cycle after hit is first sampled and lasts exactly one cycle.
  - With cyc/stb held continuously, ack toggles 1,0,1,0…
  - Ack is never asserted without hit in the prior cycle.
- Writes commit on the same edge that sets ack, i.e. the first edge with hit & ~ack.
- Read data:
  - Slave data is registered on that edge and valid while ack=1.
  - It is 16'h0 whenever ack=0, so a bus OR-mux is safe.
- Prescaler: internal 16-bit pcnt.
  - When EN=1: if pcnt==0, pcnt<=PRESCALE and tick=1; else pcnt<=pcnt-1.
  - When EN=0: pcnt<=PRESCALE, tick=0.
- On tick:
  - If COUNT!=0: COUNT<=COUNT-1.
  - If COUNT==0: EXP<=1. If AUTO=1, COUNT<=RELOAD; else EN<=0 (one-shot stops).
- irq = EXP & IRQ_EN, driven from registers, no combinational path from the bus.
- Simultaneous events:
  - Bus write to COUNT and tick in the same cycle: the write wins.
  - Bus write CTRL.EN=1 and one-shot clear of EN in the same cycle: the write wins.
  - STATUS write-1-clear and EXP set in the same cycle: the set wins (event not lost).
  - Bus write to PRESCALE does not disturb a running pcnt; the new value takes effect at the next reload.
- Arithmetic: all counters 16-bit unsigned; decrements never underflow (0 handled as expiry above).
- Reset (reset=0, asynchronous) forces to 0: CTRL, PRESCALE, COUNT, RELOAD, STATUS, pcnt, ack, slave data, irq.
  - Reset mid-transaction drops ack immediately.
  - After release, the first hit is acked one cycle later as normal.

Test Plan:
- Reset, then read offsets 0-7 with continuous cyc/stb -> every read returns 16'h0, ack pattern 0,1,0,1…, irq=0.
- Write PRESCALE=2, COUNT=3, CTRL=16'h0003 -> EXP=1 and irq=1 exactly 12 cycles after the CTRL ack edge (4 ticks × 3 cycles); CTRL reads 16'h0002 (EN auto-cleared).
- Write RELOAD=1, COUNT=1, PRESCALE=0, CTRL=16'h0005 -> EXP set every 2 cycles, COUNT cycles 1,0,1,0; write STATUS=1 clears EXP; irq stays 0 (IRQ_EN=0).
- Clear STATUS on the same cycle as an expiry -> EXP reads 1 afterwards; write COUNT=16'h00FF on a tick cycle -> COUNT reads 16'h00FF, not 16'h00FE.
- Access adr=16'h7FF0 (outside window) -> no ack, slave data 16'h0, no register change; write to offset 6 -> acked, no state change.
- Assert reset=0 during an acked read while the timer is running -> ack, irq and all registers 0 asynchronously; after release, a read of COUNT returns 16'h0.

Source files
------------

// File: rtl/wb_timer_if.sv
// Wishbone classic-cycle bus bundle between the J1 master and its data-bus responders.
// Data signal names follow the tool flow: dat_m/dat_s without modport expressions, dat_i/dat_o otherwise.
interface if_wb;
  logic [15:0] adr;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
`ifdef NO_MODPORT_EXPRESSIONS
  logic [15:0] dat_m;
  logic [15:0] dat_s;

  modport master (output adr, we, cyc, stb, dat_m, input ack, dat_s);
  modport slave  (input adr, we, cyc, stb, dat_m, output ack, dat_s);
`else
  logic [15:0] dat_i;
  logic [15:0] dat_o;

  modport master (output adr, we, cyc, stb, dat_i, input ack, dat_o);
  modport slave  (input adr, we, cyc, stb, dat_i, output ack, dat_o);
`endif
endinterface

// File: rtl/wb_timer.sv
// Prescaled 16-bit down-counter timer on an 8-word Wishbone window; registered single-cycle ack,
// reads/writes complete one cycle after hit, no stall beyond that, silent outside the window.
module wb_timer #(
  parameter logic [15:0] BASE_ADR = 16'h7FF8
) (
  input  logic clk,
  input  logic reset,
  if_wb.slave  wb,
  output logic irq
);

  logic [2:0]  ctrl;       // {AUTO, IRQ_EN, EN}
  logic [15:0] prescale;
  logic [15:0] count;
  logic [15:0] reload;
  logic [15:0] pcnt;
  logic        exp_q;
  logic        ack_q;
  logic [15:0] dat_q;
  logic [15:0] wdat;
  logic [15:0] rdata;
  logic        hit;
  logic        acc;
  logic        wr;
  logic        tick;
  logic        expire;

`ifdef NO_MODPORT_EXPRESSIONS
  assign wdat      = wb.dat_m;
  assign wb.dat_s  = dat_q;
`else
  assign wdat      = wb.dat_i;
  assign wb.dat_o  = dat_q;
`endif

  assign wb.ack = ack_q;
  assign hit    = wb.cyc & wb.stb & (wb.adr[15:3] == BASE_ADR[15:3]);
  assign acc    = hit & ~ack_q;
  assign wr     = acc & wb.we;
  assign tick   = ctrl[0] & (pcnt == 16'h0);
  assign expire = tick & (count == 16'h0);
  assign irq    = exp_q & ctrl[1];

  always_comb begin
    rdata = 16'h0;
    case (wb.adr[2:0])
      3'd0:    rdata = {13'h0, ctrl};
      3'd1:    rdata = prescale;
      3'd2:    rdata = count;
      3'd3:    rdata = reload;
      3'd4:    rdata = {15'h0, exp_q};
      default: rdata = 16'h0;
    endcase
  end

  // Read data is zero whenever ack is low so responders can be OR-ed onto the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q <= 1'b0;
      dat_q <= 16'h0;
    end else begin
      ack_q <= acc;
      dat_q <= (acc & ~wb.we) ? rdata : 16'h0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= 16'h0;
    end else if (!ctrl[0] || pcnt == 16'h0) begin
      pcnt <= prescale;
    end else begin
      pcnt <= pcnt - 16'd1;
    end
  end

  // Bus writes take priority over timer updates, except that a new expiry beats a STATUS clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= 3'h0;
      prescale <= 16'h0;
      count    <= 16'h0;
      reload   <= 16'h0;
      exp_q    <= 1'b0;
    end else begin
      if (wr && wb.adr[2:0] == 3'd0) begin
        ctrl <= wdat[2:0];
      end else if (expire && !ctrl[2]) begin
        ctrl[0] <= 1'b0;
      end

      if (wr && wb.adr[2:0] == 3'd1) begin
        prescale <= wdat;
      end

      if (wr && wb.adr[2:0] == 3'd2) begin
        count <= wdat;
      end else if (tick) begin
        if (count != 16'h0) begin
          count <= count - 16'd1;
        end else if (ctrl[2]) begin
          count <= reload;
        end
      end

      if (wr && wb.adr[2:0] == 3'd3) begin
        reload <= wdat;
      end

      if (expire) begin
        exp_q <= 1'b1;
      end else if (wr && wb.adr[2:0] == 3'd4 && wdat[0]) begin
        exp_q <= 1'b0;
      end
    end
  end

endmodule
